// File: rtl/band_energy_meter_if.sv
// Sample handshake between the PCM sampler and the band energy meter.
interface band_energy_meter_if #(
  parameter int SAMPLE_W = 8
) ();
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/band_energy_meter.sv
// Multi-band level meter: time-multiplexed difference-of-lowpass filter bank,
// windowed magnitude integration, instant or peak-hold/decay ballistic, per-band PWM.
//
// state | meaning
// IDLE  | ready for a sample; accept latches it into prev
// RUN   | one band step per cycle, k = 0 .. NUM_BANDS-1
module band_energy_meter #(
  parameter int NUM_BANDS   = 4,
  parameter int SAMPLE_W    = 8,
  parameter int WINDOW_LOG2 = 4,
  parameter int LEVEL_W     = 8,
  parameter int DECAY_STEP  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  band_energy_meter_if.slave             s_if,
  input  logic                           mode,
  output logic                           mag_valid,
  output logic [2:0]                     mag_band,
  output logic [SAMPLE_W-1:0]            mag,
  output logic [NUM_BANDS*LEVEL_W-1:0]   level_flat,
  output logic                           frame_tick,
  output logic                           overrun,
  output logic [NUM_BANDS-1:0]           pwm_out
);
  localparam int DW     = SAMPLE_W + 2;
  localparam int AW     = SAMPLE_W + WINDOW_LOG2;
  localparam int KW     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int NSLOT  = 1 << KW;
  localparam int LSHIFT = AW - LEVEL_W;
  localparam logic [KW-1:0]        LAST_K  = KW'(NUM_BANDS - 1);
  localparam logic signed [DW-1:0] MAG_MAX = DW'((1 << SAMPLE_W) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  r_state;
  logic [KW-1:0]           r_k;
  logic signed [DW-1:0]    r_prev;
  logic signed [DW-1:0]    r_lp   [NSLOT];
  logic [AW-1:0]           r_acc  [NSLOT];
  logic [LEVEL_W-1:0]      r_disp [NSLOT];
  logic [WINDOW_LOG2-1:0]  r_win;
  logic [LEVEL_W-1:0]      r_cnt;
  logic                    r_frame_tick;
  logic                    r_overrun;
  logic [NUM_BANDS-1:0]    r_pwm;

  logic signed [DW-1:0]    w_lp_cur, w_diff, w_step, w_lp_new, w_b, w_abs;
  logic [KW:0]             w_shift;
  logic [SAMPLE_W-1:0]     w_mag;
  logic [AW-1:0]           w_sum;
  logic [LEVEL_W-1:0]      w_level, w_decayed, w_peak;
  logic                    w_run, w_last_band, w_last_sample;

  always_comb begin
    w_lp_cur  = r_lp[r_k];
    w_shift   = {1'b0, r_k} + (KW+1)'(1);
    w_diff    = r_prev - w_lp_cur;
    w_step    = w_diff >>> w_shift;
    w_lp_new  = w_lp_cur + w_step;
    w_b       = r_prev - w_lp_new;
    w_abs     = w_b[DW-1] ? -w_b : w_b;
    w_mag     = (w_abs > MAG_MAX) ? MAG_MAX[SAMPLE_W-1:0] : w_abs[SAMPLE_W-1:0];
    // The final sample's magnitude is folded into the level directly, not via acc.
    w_sum     = r_acc[r_k] + AW'(w_mag);
    w_level   = LEVEL_W'(w_sum >> LSHIFT);
    w_decayed = (int'(r_disp[r_k]) > DECAY_STEP) ? r_disp[r_k] - LEVEL_W'(DECAY_STEP) : '0;
    w_peak    = (w_level > w_decayed) ? w_level : w_decayed;
    w_run         = (r_state == RUN);
    w_last_band   = (r_k == LAST_K);
    w_last_sample = (r_win == '1);
  end

  assign s_if.sample_ready = (r_state == IDLE);
  assign mag_valid         = w_run;
  assign mag_band          = w_run ? 3'(r_k) : 3'd0;
  assign mag               = w_run ? w_mag : '0;
  assign frame_tick        = r_frame_tick;
  assign overrun           = r_overrun;
  assign pwm_out           = r_pwm;

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_level
    assign level_flat[g*LEVEL_W +: LEVEL_W] = r_disp[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_prev       <= '0;
      r_win        <= '0;
      r_cnt        <= '0;
      r_frame_tick <= 1'b0;
      r_overrun    <= 1'b0;
      r_pwm        <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_lp[i]   <= '0;
        r_acc[i]  <= '0;
        r_disp[i] <= '0;
      end
    end else begin
      r_cnt        <= r_cnt + LEVEL_W'(1);
      r_frame_tick <= 1'b0;
      if (s_if.sample_valid && (r_state != IDLE))
        r_overrun <= 1'b1;
      for (int i = 0; i < NUM_BANDS; i++)
        r_pwm[i] <= (r_cnt < r_disp[i]);

      case (r_state)
        IDLE: begin
          if (s_if.sample_valid) begin
            r_prev  <= {{2{s_if.sample_in[SAMPLE_W-1]}}, s_if.sample_in};
            r_k     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_lp[r_k] <= w_lp_new;
          r_prev    <= w_lp_new;
          if (w_last_sample) begin
            r_acc[r_k]  <= '0;
            r_disp[r_k] <= mode ? w_peak : w_level;
          end else begin
            r_acc[r_k]  <= w_sum;
          end
          if (w_last_band) begin
            r_state      <= IDLE;
            r_win        <= r_win + WINDOW_LOG2'(1);
            r_frame_tick <= w_last_sample;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_band_energy_meter.sv
// Scoreboard bench for band_energy_meter: integer reference model feeds queues, monitor compares.
module tb_band_energy_meter;
  localparam int NB = 4;
  localparam int SW = 8;
  localparam int WL = 4;
  localparam int LW = 8;
  localparam int DS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic            mag_valid;
  logic [2:0]      mag_band;
  logic [SW-1:0]   mag;
  logic [NB*LW-1:0] level_flat;
  logic            frame_tick;
  logic            overrun;
  logic [NB-1:0]   pwm_out;

  band_energy_meter_if #(.SAMPLE_W(SW)) bus ();

  band_energy_meter #(
    .NUM_BANDS(NB), .SAMPLE_W(SW), .WINDOW_LOG2(WL), .LEVEL_W(LW), .DECAY_STEP(DS)
  ) dut (
    .clk(clk), .rst(rst), .s_if(bus), .mode(mode),
    .mag_valid(mag_valid), .mag_band(mag_band), .mag(mag),
    .level_flat(level_flat), .frame_tick(frame_tick), .overrun(overrun), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int m_lp [NB];
  int m_acc[NB];
  int m_disp[NB];
  int m_win;
  int q_band[$];
  int q_mag[$];
  int q_lvl[$];
  int tests = 0;
  int fails = 0;
  int n_ticks = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NB; k++) begin
      m_lp[k] = 0; m_acc[k] = 0; m_disp[k] = 0;
    end
    m_win = 0;
    q_band.delete(); q_mag.delete(); q_lvl.delete();
  endfunction

  // Filter bank and window ballistics computed straight from the arithmetic rules.
  function automatic void model_push(input int x);
    int prev, lp_new, b, mg, lvl, dec;
    prev = x;
    for (int k = 0; k < NB; k++) begin
      lp_new  = m_lp[k] + ((prev - m_lp[k]) >>> (k + 1));
      m_lp[k] = lp_new;
      b       = prev - lp_new;
      prev    = lp_new;
      mg      = (b < 0) ? -b : b;
      if (mg > (1 << SW) - 1) mg = (1 << SW) - 1;
      q_band.push_back(k);
      q_mag.push_back(mg);
      m_acc[k] += mg;
      if (m_win == (1 << WL) - 1) begin
        lvl      = m_acc[k] >> (SW + WL - LW);
        m_acc[k] = 0;
        if (mode) begin
          dec = m_disp[k] - DS;
          if (dec < 0) dec = 0;
          m_disp[k] = (lvl > dec) ? lvl : dec;
        end else begin
          m_disp[k] = lvl;
        end
        q_lvl.push_back(m_disp[k]);
      end
    end
    m_win = (m_win + 1) % (1 << WL);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mag_valid) begin
        if (q_band.size() == 0) check("unexpected_mag_valid", mag_valid, 0);
        else begin
          check("mag_band", mag_band, q_band.pop_front());
          check("mag", mag, q_mag.pop_front());
        end
      end
      if (frame_tick) begin
        n_ticks++;
        if (q_lvl.size() < NB) check("spurious_frame_tick", frame_tick, 0);
        else
          for (int k = 0; k < NB; k++)
            check($sformatf("level[%0d]", k), level_flat[k*LW +: LW], q_lvl.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    tick();
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, bus.sample_ready, 1);
    check({tag, "_mag_valid"}, mag_valid, 0);
    check({tag, "_mag"}, mag, 0);
    check({tag, "_mag_band"}, mag_band, 0);
    check({tag, "_frame_tick"}, frame_tick, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_pwm"}, pwm_out, 0);
    check({tag, "_level_flat"}, level_flat, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.sample_ready && n < 50) begin tick(); n++; end
    if (!bus.sample_ready) check("idle_timeout", bus.sample_ready, 1);
  endtask

  task automatic send(input int x);
    int n = 0;
    bus.sample_in    = x[SW-1:0];
    bus.sample_valid = 1'b1;
    while (!bus.sample_ready && n < 50) begin tick(); n++; end
    if (!bus.sample_ready) check("ready_timeout", bus.sample_ready, 1);
    else model_push(x);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pwm_check(input string tag);
    int cnt[NB];
    wait_idle();
    tick(); tick();
    for (int k = 0; k < NB; k++) cnt[k] = 0;
    repeat (256) begin
      for (int k = 0; k < NB; k++) if (pwm_out[k]) cnt[k]++;
      tick();
    end
    for (int k = 0; k < NB; k++) check($sformatf("%s_pwm_duty[%0d]", tag, k), cnt[k], m_disp[k]);
  endtask

  function automatic int rand_loud();
    int v;
    v = 100 + int'($urandom_range(27));
    return ($urandom_range(1) != 0) ? v : -v;
  endfunction

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    model_reset();
    do_reset();
    check_reset("por");
    pwm_check("zero");

    // First sample: band steps and ready timing.
    bus.sample_in    = 8'sd64;
    bus.sample_valid = 1'b1;
    check("first_accept_ready", bus.sample_ready, 1);
    model_push(64);
    tick();
    bus.sample_valid = 1'b0;
    for (int i = 1; i <= NB; i++) begin
      check($sformatf("ready_low_T+%0d", i), bus.sample_ready, 0);
      tick();
    end
    check("ready_high_T+5", bus.sample_ready, 1);

    // Instant window of constant +64.
    do_reset();
    mode    = 1'b0;
    n_ticks = 0;
    repeat ((1 << WL) - 1) send(64);
    wait_idle();
    repeat (3) tick();
    check("ticks_before_window_end", n_ticks, 0);
    send(64);
    wait_idle();
    repeat (3) tick();
    check("ticks_after_window", n_ticks, 1);
    pwm_check("inst64");

    // Random instant windows.
    repeat (2 * (1 << WL)) send(int'($urandom_range(255)) - 128);
    pwm_check("inst_rand");

    // Reset mid-RUN on what would be the window's final sample.
    do_reset();
    repeat ((1 << WL) - 1) send(rand_loud());
    wait_idle();
    n_ticks = 0;
    bus.sample_in    = 8'sd90;
    bus.sample_valid = 1'b1;
    check("midrun_accept_ready", bus.sample_ready, 1);
    model_push(90);
    tick();
    bus.sample_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_reset("midrun");
    repeat (NB + 3) tick();
    check("midrun_no_frame_tick", n_ticks, 0);

    // Peak-hold: one loud window then quiet windows decaying to the floor.
    mode = 1'b1;
    repeat (1 << WL) send(rand_loud());
    pwm_check("peak_loud");
    for (int w = 0; w < 8; w++) begin
      repeat (1 << WL) send(int'($urandom_range(4)) - 2);
      if (w == 3 || w == 7) pwm_check($sformatf("peak_quiet%0d", w));
    end
    mode = 1'b0;

    // Overrun: valid held through the busy cycles.
    do_reset();
    check("overrun_clear", overrun, 0);
    bus.sample_in    = 8'sd64;
    bus.sample_valid = 1'b1;
    check("ovr_accept_ready", bus.sample_ready, 1);
    model_push(64);
    tick();
    bus.sample_in = -8'sd37;
    for (int i = 1; i <= NB; i++) begin
      check($sformatf("ovr_ready_low_T+%0d", i), bus.sample_ready, 0);
      tick();
    end
    check("ovr_ready_T+5", bus.sample_ready, 1);
    model_push(-37);
    tick();
    bus.sample_valid = 1'b0;
    check("overrun_set", overrun, 1);
    repeat (3) send(int'($urandom_range(255)) - 128);
    wait_idle();
    repeat (3) tick();
    check("overrun_sticky", overrun, 1);

    check("mag_queue_drained", q_mag.size(), 0);
    check("level_queue_drained", q_lvl.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
